// File: rtl/req_pick_queue_if.sv
// Handshake and status bundle for req_pick_queue: request and cancel vectors, the issue slot,
// and the pending-state monitors.
interface req_pick_queue_if #(
    parameter int IN = 8
);
    logic                       flush;
    logic [IN-1:0]              set_vec;
    logic [IN-1:0]              cancel_vec;
    logic                       out_valid;
    logic [$clog2(IN)-1:0]      out_idx;
    logic                       out_ready;
    logic [IN-1:0]              pend_vec;
    logic [$clog2(IN+1)-1:0]    pend_cnt;
    logic                       empty;

    modport slave (
        input  flush, set_vec, cancel_vec, out_ready,
        output out_valid, out_idx, pend_vec, pend_cnt, empty
    );

    modport master (
        output flush, set_vec, cancel_vec, out_ready,
        input  out_valid, out_idx, pend_vec, pend_cnt, empty
    );
endinterface

// File: rtl/req_pick_queue.sv
// Sticky request collector: gathers request bits into a pending vector and issues the highest
// pending index, one per cycle, into a registered valid/ready output slot.
module req_pick_queue #(
    parameter  int IN  = 8,
    localparam int OUT = $clog2(IN),
    localparam int CNT = $clog2(IN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    req_pick_queue_if.slave bus
);

    logic [IN-1:0]  pend_r;
    logic           out_valid_r;
    logic [OUT-1:0] out_idx_r;

    logic [IN-1:0]  elig_s;
    logic [IN-1:0]  clr_s;
    logic [IN-1:0]  pend_nxt_s;
    logic           load_s;
    logic           any_s;
    logic [OUT-1:0] win_s;

    // Highest set index wins, matching pri_enc with active-high inputs.
    function automatic logic [OUT-1:0] hi_index(input logic [IN-1:0] v);
        logic [OUT-1:0] idx;
        idx = '0;
        for (int i = 0; i < IN; i++) begin
            if (v[i]) begin
                idx = OUT'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [IN-1:0] onehot(input logic [OUT-1:0] idx);
        return {{(IN-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [CNT-1:0] popcount(input logic [IN-1:0] v);
        logic [CNT-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < IN; i++) begin
            cnt = cnt + {{(CNT-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Pick the winner among non-cancelled pending bits and form the next pending vector.
    always_comb begin
        elig_s = pend_r & ~bus.cancel_vec;
        any_s  = |elig_s;
        load_s = !out_valid_r || bus.out_ready;
        win_s  = hi_index(elig_s);
        if (load_s && any_s) begin
            clr_s = onehot(win_s);
        end else begin
            clr_s = '0;
        end
        // New requests land after the pick-clear so a same-cycle set keeps the bit pending.
        pend_nxt_s = (elig_s & ~clr_s) | bus.set_vec;
    end

    // Pending vector and output slot registers; flush acts as the synchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r      <= '0;
            out_valid_r <= 1'b0;
            out_idx_r   <= '0;
        end else if (bus.flush) begin
            pend_r      <= '0;
            out_valid_r <= 1'b0;
            out_idx_r   <= '0;
        end else begin
            pend_r <= pend_nxt_s;
            if (load_s) begin
                out_valid_r <= any_s;
                if (any_s) begin
                    out_idx_r <= win_s;
                end else begin
                    out_idx_r <= out_idx_r;
                end
            end else begin
                out_valid_r <= out_valid_r;
                out_idx_r   <= out_idx_r;
            end
        end
    end

    assign bus.pend_vec  = pend_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.pend_cnt  = popcount(pend_r);
    assign bus.empty     = ~(|pend_r) & ~out_valid_r;

endmodule

// File: tb/tb_req_pick_queue.sv
// Self-checking bench for req_pick_queue: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_req_pick_queue;
    localparam int IN = 8;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    req_pick_queue_if #(.IN(IN)) bus();

    req_pick_queue #(.IN(IN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: pending set as a bit vector, output slot as valid + index.
    logic [IN-1:0] m_pend, n_pend;
    bit            m_valid, n_valid;
    int            m_idx, n_idx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend  <= '0;
            m_valid <= 1'b0;
            m_idx   <= 0;
        end else begin
            m_pend  <= n_pend;
            m_valid <= n_valid;
            m_idx   <= n_idx;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compute what the next state must be from the current model state and this cycle's inputs.
    task automatic model_next(input logic [IN-1:0] s, input logic [IN-1:0] c,
                              input bit r, input bit f);
        int w;
        bit ld;
        if (f) begin
            n_pend  = '0;
            n_valid = 1'b0;
            n_idx   = m_idx;
            return;
        end
        ld = !m_valid || r;
        w  = -1;
        for (int i = IN - 1; i >= 0; i--) begin
            if (w < 0 && m_pend[i] && !c[i]) w = i;
        end
        n_pend = m_pend & ~c;
        if (ld && w >= 0) n_pend[w] = 1'b0;
        n_pend  = n_pend | s;
        n_valid = ld ? (w >= 0) : m_valid;
        n_idx   = (ld && w >= 0) ? w : m_idx;
    endtask

    // Drive one cycle of inputs (called at posedge+2), then return at the next posedge+2.
    task automatic cyc(input logic [IN-1:0] s, input logic [IN-1:0] c, input bit r, input bit f);
        bus.set_vec    = s;
        bus.cancel_vec = c;
        bus.out_ready  = r;
        bus.flush      = f;
        model_next(s, c, r, f);
        @(posedge clk);
        #2;
    endtask

    // Every-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_valid", int'(bus.out_valid), int'(m_valid));
            chk("cmp_pend", int'(bus.pend_vec), int'(m_pend));
            chk("cmp_cnt", int'(bus.pend_cnt), $countones(m_pend));
            chk("cmp_empty", int'(bus.empty), int'(m_pend == '0 && !m_valid));
            if (m_valid) chk("cmp_idx", int'(bus.out_idx), m_idx);
        end
    end

    initial begin
        int exp_seq[3];
        logic [IN-1:0] rs, rc;
        n_cmp = 0;
        n_bad = 0;
        n_pend = '0;
        n_valid = 1'b0;
        n_idx = 0;
        reset = 1'b1;
        bus.set_vec = '0;
        bus.cancel_vec = '0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_pend", int'(bus.pend_vec), 0);
        chk("rst_cnt", int'(bus.pend_cnt), 0);
        chk("rst_empty", int'(bus.empty), 1);

        // Basic pick order 5, 2, 0.
        cyc(8'b0010_0101, 8'h00, 1'b1, 1'b0);
        chk("basic_pend", int'(bus.pend_vec), 8'h25);
        chk("basic_novalid", int'(bus.out_valid), 0);
        chk("model_pend_pin", int'(m_pend), 8'h25);
        exp_seq[0] = 5; exp_seq[1] = 2; exp_seq[2] = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(8'h00, 8'h00, 1'b1, 1'b0);
            chk("basic_valid", int'(bus.out_valid), 1);
            chk("basic_idx", int'(bus.out_idx), exp_seq[k]);
        end
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        chk("basic_drain", int'(bus.out_valid), 0);
        chk("basic_empty", int'(bus.empty), 1);

        // Backpressure on a full pending vector.
        cyc(8'hFF, 8'h00, 1'b0, 1'b0);
        chk("full_cnt", int'(bus.pend_cnt), 8);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(8'h00, 8'h00, 1'b0, 1'b0);
            chk("hold_idx", int'(bus.out_idx), 7);
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_cnt", int'(bus.pend_cnt), 7);
        end
        for (int k = 6; k >= 0; k--) begin
            cyc(8'h00, 8'h00, 1'b1, 1'b0);
            chk("release_idx", int'(bus.out_idx), k);
        end
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        chk("release_empty", int'(bus.empty), 1);

        // Set and cancel on the same pending bit: set wins, nothing issues that cycle.
        cyc(8'h80, 8'h00, 1'b0, 1'b0);
        cyc(8'h80, 8'h80, 1'b0, 1'b0);
        chk("race_pend", int'(bus.pend_vec), 8'h80);
        chk("race_novalid", int'(bus.out_valid), 0);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        chk("race_idx", int'(bus.out_idx), 7);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);

        // Set beats pick-clear: 7 is issued twice.
        cyc(8'h80, 8'h00, 1'b1, 1'b0);
        cyc(8'h80, 8'h00, 1'b1, 1'b0);
        chk("setpick_idx", int'(bus.out_idx), 7);
        chk("setpick_pend", int'(bus.pend_vec), 8'h80);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        chk("setpick_idx2", int'(bus.out_idx), 7);
        chk("setpick_valid2", int'(bus.out_valid), 1);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);

        // Cancel-only: no issue.
        cyc(8'h80, 8'h00, 1'b1, 1'b0);
        cyc(8'h00, 8'h80, 1'b1, 1'b0);
        chk("cancel_novalid", int'(bus.out_valid), 0);
        chk("cancel_empty", int'(bus.empty), 1);

        // Re-set of the held entry.
        cyc(8'h08, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        cyc(8'h08, 8'h00, 1'b0, 1'b0);
        chk("reset_held_idx", int'(bus.out_idx), 3);
        chk("reset_held_pend", int'(bus.pend_vec), 8'h08);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        chk("reset_held_idx2", int'(bus.out_idx), 3);
        chk("reset_held_pend2", int'(bus.pend_vec), 8'h00);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);

        // Flush overrides set and pick.
        cyc(8'hDA, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        chk("flush_pre_pend", int'(bus.pend_vec), 8'h5A);
        chk("flush_pre_valid", int'(bus.out_valid), 1);
        cyc(8'h01, 8'h00, 1'b1, 1'b1);
        chk("flush_pend", int'(bus.pend_vec), 8'h00);
        chk("flush_valid", int'(bus.out_valid), 0);

        // Asynchronous reset in the middle of a cycle.
        cyc(8'hF0, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("areset_valid", int'(bus.out_valid), 0);
        chk("areset_pend", int'(bus.pend_vec), 0);
        chk("areset_cnt", int'(bus.pend_cnt), 0);
        chk("areset_empty", int'(bus.empty), 1);
        #1;
        reset = 1'b0;
        cyc(8'h00, 8'h00, 1'b0, 1'b0);

        // Randomized traffic checked by the every-cycle compare.
        for (int k = 0; k < 2000; k++) begin
            rs = ($urandom_range(0, 3) == 0) ? IN'($urandom) : '0;
            rc = ($urandom_range(0, 5) == 0) ? IN'($urandom) : '0;
            cyc(rs, rc, $urandom_range(0, 2) != 0, $urandom_range(0, 80) == 0);
        end
        cyc(8'h00, 8'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
